pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central pipeline control unit for the 5-stage core (IF, ID, EX, DM, WB).
- Drives the enable, stall and active-low clear inputs of the four inter-stage pipeline registers and the PC register.
- Resolves load-use hazards, taken-branch flushes, interrupt entry (drain, then redirect) and the terminal halt.
- Forwarding muxes are outside this block.

Parameters:
- DRAIN_CYCLES, 3, cycles the front end stays frozen after interrupt accept so that the EX, DM and WB occupants retire.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction (not a bubble)
- id_pc  in  `IM_ADDR_BIT  PC of the instruction in ID
- id_rs_used  in  1  ID instruction reads rs
- id_rt_used  in  1  ID instruction reads rt
- id_rs  in  5  rs index
- id_rt  in  5  rt index
- ex_load  in  1  EX instruction is a data-memory read
- ex_req_w  in  5  EX destination register
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- int_pending  in  1  level request from the interrupt controller
- wb_halt  in  1  syscall halt reached WB
- pc_en  out  1  PC register load enable
- pc_sel  out  2  0 sequential, 1 branch target, 2 interrupt vector
- if_id_en, if_id_stall, if_id_clr  out  1 each  IF/ID controls; clr is active-low
- id_ex_en, id_ex_clr  out  1 each  ID/EX controls; clr is active-low
- ex_dm_en, ex_dm_clr  out  1 each  EX/DM controls
- dm_wb_en, dm_wb_clr  out  1 each  DM/WB controls
- inting  out  1  one-cycle interrupt-entry marker, captured by ID/EX
- epc  out  `IM_ADDR_BIT  return address latched at accept
- halted  out  1  core halted
- stall_cnt  out  CNT_W  count of frozen-PC cycles

Behaviour:
- All `*_clr` outputs are active-low: 0 means flush the register on this edge.

Registered state and reset values
- Registered: state, drain counter, epc, halted, stall_cnt.
- On rst_n low (asynchronous): state=RUN, counter=0, epc=0, halted=0, stall_cnt=0.

Combinational outputs and their defaults
- All other outputs are combinational from state and inputs.
- RUN defaults: all en=1, all clr=1, if_id_stall=0, pc_sel=0, pc_en=1, inting=0.
- These defaults are also the values driven during reset.

Hazard detect (RUN only)
- lu = ex_load & ex_req_w!=0 & ((id_rs_used & id_rs==ex_req_w) | (id_rt_used & id_rt==ex_req_w)).

State RUN, evaluated in priority order
1. wb_halt: go to HALT. This cycle all en=0.
2. ex_branch_taken: pc_sel=1, pc_en=1, if_id_clr=0, id_ex_clr=0. Branch wins over lu because the ID instruction is wrong-path.
3. int_pending & id_valid & !lu: accept the interrupt.
   - epc<=id_pc; counter<=DRAIN_CYCLES-1; go to DRAIN.
   - This cycle: pc_en=0, if_id_clr=0, id_ex_clr=0.
4. lu: pc_en=0, if_id_stall=1, id_ex_clr=0 (one bubble). Stays in RUN.
   - The stall lasts exactly 1 cycle: after the edge the load is in DM.
5. Otherwise: defaults.

State DRAIN
- Outputs: pc_en=0, if_id_clr=0, id_ex_clr=0. EX/DM and DM/WB advance normally.
- counter==0: go to VECTOR. Otherwise decrement the counter.
- wb_halt in DRAIN: go to HALT (halt dominates; the interrupt is dropped).

State VECTOR (1 cycle)
- Outputs: pc_sel=2, pc_en=1, inting=1, if_id_clr=0. Then return to RUN.

State HALT
- Outputs: every en=0, pc_en=0, halted=1.
- Absorbing; leaves only through rst_n.

Counter and boundary rules
- stall_cnt increments on every cycle with pc_en==0 in RUN or DRAIN. It saturates at all-ones and does not wrap.
- int_pending is ignored while in DRAIN, VECTOR or HALT.
- A taken branch on the accept cycle blocks the accept; the interrupt retries on a later cycle.
- rst_n asserted mid-DRAIN returns to RUN immediately with epc=0.

Decomposition:
- Shared constants go in Core.vh:
  - PC_SEL_SEQ=0, PC_SEL_BR=1, PC_SEL_INT=2, PC_SEL_BIT=2;
  - state encodings HZ_RUN, HZ_DRAIN, HZ_VECTOR, HZ_HALT.
- One natural sub-module: hazard_load_use_detect, purely combinational, producing lu.
- The FSM and counters stay in the top.

Test Plan:
- lw $t0 in EX (ex_req_w=8), ID add reads rs=8 → one cycle: pc_en=0, if_id_stall=1, id_ex_clr=0, stall_cnt 0→1; next cycle defaults.
- Same hazard but ex_req_w=0 → no stall; all outputs at defaults.
- ex_branch_taken=1 together with lu → pc_sel=1, if_id_clr=0, id_ex_clr=0, pc_en=1; no stall.
- int_pending=1, id_valid=1, id_pc=0x40, DRAIN_CYCLES=3:
  - accept cycle plus 3 DRAIN cycles with pc_en=0;
  - then VECTOR with pc_sel=2, inting=1;
  - epc=0x40, stall_cnt=4.
- wb_halt=1 during DRAIN → HALT: halted=1, all en=0; int_pending ignored; rst_n low returns to RUN with halted=0.
- Force 1000 stall cycles with stall_cnt preloaded near saturation via CNT_W=4 → counter holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the 5-stage core pipeline control: PC select codes,
// address/register widths and the hazard controller state encoding.
package pipeline_hazard_ctrl_pkg;

  localparam int IM_ADDR_BIT = 32;
  localparam int REG_IDX_W   = 5;
  localparam int PC_SEL_BIT  = 2;

  localparam logic [PC_SEL_BIT-1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [PC_SEL_BIT-1:0] PC_SEL_BR  = 2'd1;
  localparam logic [PC_SEL_BIT-1:0] PC_SEL_INT = 2'd2;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_DRAIN  = 2'd1,
    HZ_VECTOR = 2'd2,
    HZ_HALT   = 2'd3
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_lu_detect.sv
// Load-use hazard detect: the ID instruction reads a register that the load
// currently in EX has not yet fetched from data memory.
module hazard_load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic                 ex_load,
  input  logic [REG_IDX_W-1:0] ex_req_w,
  input  logic                 id_rs_used,
  input  logic                 id_rt_used,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  output logic                 lu
);

  logic rs_hit;
  logic rt_hit;

  // $zero is never a real dependency, so a load targeting r0 cannot stall.
  assign rs_hit = id_rs_used && (id_rs == ex_req_w);
  assign rt_hit = id_rt_used && (id_rt == ex_req_w);
  assign lu     = ex_load && (ex_req_w != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline control: load-use stall, branch flush, interrupt drain and
// redirect, terminal halt, plus a saturating frozen-PC cycle counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [IM_ADDR_BIT-1:0] id_pc,
  input  logic                   id_rs_used,
  input  logic                   id_rt_used,
  input  logic [REG_IDX_W-1:0]   id_rs,
  input  logic [REG_IDX_W-1:0]   id_rt,
  input  logic                   ex_load,
  input  logic [REG_IDX_W-1:0]   ex_req_w,
  input  logic                   ex_branch_taken,
  input  logic                   int_pending,
  input  logic                   wb_halt,
  output logic                   pc_en,
  output logic [PC_SEL_BIT-1:0]  pc_sel,
  output logic                   if_id_en,
  output logic                   if_id_stall,
  output logic                   if_id_clr,
  output logic                   id_ex_en,
  output logic                   id_ex_clr,
  output logic                   ex_dm_en,
  output logic                   ex_dm_clr,
  output logic                   dm_wb_en,
  output logic                   dm_wb_clr,
  output logic                   inting,
  output logic [IM_ADDR_BIT-1:0] epc,
  output logic                   halted,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int              DC_W     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DC_W-1:0] CNT_LOAD = DC_W'(DRAIN_CYCLES - 1);

  hz_state_e              state_q, state_d;
  logic [DC_W-1:0]        drain_q, drain_d;
  logic [IM_ADDR_BIT-1:0] epc_q, epc_d;
  logic                   halted_q, halted_d;
  logic [CNT_W-1:0]       stall_q, stall_d;
  logic                   lu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  hazard_load_use_detect u_lu (
    .ex_load    (ex_load),
    .ex_req_w   (ex_req_w),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .lu         (lu)
  );

  // Outputs fall back to the RUN defaults while reset is held, whatever the inputs.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    epc_d       = epc_q;
    halted_d    = halted_q;
    pc_en       = 1'b1;
    pc_sel      = PC_SEL_SEQ;
    if_id_en    = 1'b1;
    if_id_stall = 1'b0;
    if_id_clr   = 1'b1;
    id_ex_en    = 1'b1;
    id_ex_clr   = 1'b1;
    ex_dm_en    = 1'b1;
    ex_dm_clr   = 1'b1;
    dm_wb_en    = 1'b1;
    dm_wb_clr   = 1'b1;
    inting      = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        HZ_RUN: begin
          if (wb_halt) begin
            state_d  = HZ_HALT;
            halted_d = 1'b1;
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            ex_dm_en = 1'b0;
            dm_wb_en = 1'b0;
          end else if (ex_branch_taken) begin
            pc_sel    = PC_SEL_BR;
            if_id_clr = 1'b0;
            id_ex_clr = 1'b0;
          end else if (int_pending && id_valid && !lu) begin
            state_d   = HZ_DRAIN;
            drain_d   = CNT_LOAD;
            epc_d     = id_pc;
            pc_en     = 1'b0;
            if_id_clr = 1'b0;
            id_ex_clr = 1'b0;
          end else if (lu) begin
            pc_en       = 1'b0;
            if_id_stall = 1'b1;
            id_ex_clr   = 1'b0;
          end
        end
        HZ_DRAIN: begin
          pc_en     = 1'b0;
          if_id_clr = 1'b0;
          id_ex_clr = 1'b0;
          if (wb_halt) begin
            state_d  = HZ_HALT;
            halted_d = 1'b1;
          end else if (drain_q == '0) begin
            state_d = HZ_VECTOR;
          end else begin
            drain_d = drain_q - DC_W'(1);
          end
        end
        HZ_VECTOR: begin
          pc_sel    = PC_SEL_INT;
          inting    = 1'b1;
          if_id_clr = 1'b0;
          state_d   = HZ_RUN;
        end
        HZ_HALT: begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          id_ex_en = 1'b0;
          ex_dm_en = 1'b0;
          dm_wb_en = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (((state_q == HZ_RUN) || (state_q == HZ_DRAIN)) && !pc_en) begin
      stall_d = sat_inc(stall_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HZ_RUN;
      drain_q  <= '0;
      epc_q    <= '0;
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      epc_q    <= epc_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
    end
  end

  assign epc       = epc_q;
  assign halted    = halted_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int DC  = 3;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs_used, id_rt_used, ex_load, ex_branch_taken;
  logic        int_pending, wb_halt;
  logic [31:0] id_pc;
  logic [4:0]  id_rs, id_rt, ex_req_w;
  logic        pc_en, if_id_en, if_id_stall, if_id_clr, id_ex_en, id_ex_clr;
  logic        ex_dm_en, ex_dm_clr, dm_wb_en, dm_wb_clr, inting, halted;
  logic [1:0]  pc_sel;
  logic [31:0] epc;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rs(id_rs), .id_rt(id_rt),
    .ex_load(ex_load), .ex_req_w(ex_req_w), .ex_branch_taken(ex_branch_taken),
    .int_pending(int_pending), .wb_halt(wb_halt), .pc_en(pc_en), .pc_sel(pc_sel),
    .if_id_en(if_id_en), .if_id_stall(if_id_stall), .if_id_clr(if_id_clr),
    .id_ex_en(id_ex_en), .id_ex_clr(id_ex_clr), .ex_dm_en(ex_dm_en), .ex_dm_clr(ex_dm_clr),
    .dm_wb_en(dm_wb_en), .dm_wb_clr(dm_wb_clr), .inting(inting), .epc(epc),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  // Behavioural model: halted flag, vector-next flag, drain cycles remaining.
  bit          m_halted = 1'b0;
  bit          m_vec    = 1'b0;
  int          m_drain  = 0;
  logic [31:0] m_epc    = '0;
  int          m_stall  = 0;

  logic        e_pc_en, e_stall, e_ifclr, e_idexclr, e_en, e_int, m_lu;
  logic [1:0]  e_sel;
  logic [13:0] e_ctrl, a_ctrl;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_halted = 1'b0; m_vec = 1'b0; m_drain = 0; m_epc = '0; m_stall = 0;
    end
    e_pc_en = 1'b1; e_sel = 2'd0; e_stall = 1'b0; e_ifclr = 1'b1;
    e_idexclr = 1'b1; e_en = 1'b1; e_int = 1'b0;
    m_lu = ex_load && (ex_req_w != 5'd0) &&
           ((id_rs_used && id_rs == ex_req_w) || (id_rt_used && id_rt == ex_req_w));
    if (rst_n) begin
      if (m_halted) begin
        e_en = 1'b0; e_pc_en = 1'b0;
      end else if (m_vec) begin
        e_sel = 2'd2; e_int = 1'b1; e_ifclr = 1'b0;
      end else if (m_drain > 0) begin
        e_pc_en = 1'b0; e_ifclr = 1'b0; e_idexclr = 1'b0;
      end else if (wb_halt) begin
        e_en = 1'b0; e_pc_en = 1'b0;
      end else if (ex_branch_taken) begin
        e_sel = 2'd1; e_ifclr = 1'b0; e_idexclr = 1'b0;
      end else if (int_pending && id_valid && !m_lu) begin
        e_pc_en = 1'b0; e_ifclr = 1'b0; e_idexclr = 1'b0;
      end else if (m_lu) begin
        e_pc_en = 1'b0; e_stall = 1'b1; e_idexclr = 1'b0;
      end
    end
    e_ctrl = {e_pc_en, e_sel, e_en, e_stall, e_ifclr, e_en, e_idexclr,
              e_en, 1'b1, e_en, 1'b1, e_int, m_halted};
    a_ctrl = {pc_en, pc_sel, if_id_en, if_id_stall, if_id_clr, id_ex_en, id_ex_clr,
              ex_dm_en, ex_dm_clr, dm_wb_en, dm_wb_clr, inting, halted};
    checks++;
    if (a_ctrl !== e_ctrl) begin
      errors++;
      $display("FAIL ctrl t=%0t actual=%b required=%b", $time, a_ctrl, e_ctrl);
    end
    checks++;
    if (epc !== m_epc) begin
      errors++;
      $display("FAIL epc t=%0t actual=%0h required=%0h", $time, epc, m_epc);
    end
    checks++;
    if (32'(stall_cnt) !== m_stall) begin
      errors++;
      $display("FAIL stall_cnt t=%0t actual=%0d required=%0d", $time, stall_cnt, m_stall);
    end
    if (rst_n && !m_halted) begin
      if (!m_vec && !e_pc_en && m_stall < SAT) m_stall++;
      if (m_vec) begin
        m_vec = 1'b0;
      end else if (m_drain > 0) begin
        if (wb_halt) begin
          m_halted = 1'b1; m_drain = 0;
        end else begin
          m_drain--;
          if (m_drain == 0) m_vec = 1'b1;
        end
      end else if (wb_halt) begin
        m_halted = 1'b1;
      end else if (!ex_branch_taken && int_pending && id_valid && !m_lu) begin
        m_drain = DC; m_epc = id_pc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_pc = '0; id_rs_used = 0; id_rt_used = 0; id_rs = '0; id_rt = '0;
    ex_load = 0; ex_req_w = '0; ex_branch_taken = 0; int_pending = 0; wb_halt = 0;
  endtask

  task automatic load_use(input logic [4:0] r);
    id_valid = 1; id_rs_used = 1; id_rs = r; ex_load = 1; ex_req_w = r;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    step(); rst_n = 0; idle(); settle();
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    step(); rst_n = 1;
  endtask

  initial begin
    idle(); rst_n = 0;
    // Hazardous inputs during reset must still yield defaults.
    load_use(5'd8); settle();
    chk("rst_pc_en", 32'(pc_en), 32'd1);
    chk("rst_if_id_stall", 32'(if_id_stall), 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_stall_cnt0", 32'(stall_cnt), 32'd0);
    step(); idle(); rst_n = 1;

    step(); load_use(5'd8); settle();
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_if_id_stall", 32'(if_id_stall), 32'd1);
    chk("lu_id_ex_clr", 32'(id_ex_clr), 32'd0);
    chk("lu_cnt_before", 32'(stall_cnt), 32'd0);
    step(); idle(); settle();
    chk("lu_cnt_after", 32'(stall_cnt), 32'd1);
    chk("lu_release_pc_en", 32'(pc_en), 32'd1);

    step(); load_use(5'd0); settle();
    chk("r0_pc_en", 32'(pc_en), 32'd1);
    chk("r0_if_id_stall", 32'(if_id_stall), 32'd0);

    step(); load_use(5'd9); ex_branch_taken = 1; settle();
    chk("br_pc_sel", 32'(pc_sel), 32'd1);
    chk("br_pc_en", 32'(pc_en), 32'd1);
    chk("br_if_id_clr", 32'(if_id_clr), 32'd0);
    chk("br_if_id_stall", 32'(if_id_stall), 32'd0);

    do_reset();
    step(); idle(); id_valid = 1; id_pc = 32'h40; int_pending = 1; settle();
    chk("acc_pc_en", 32'(pc_en), 32'd0);
    for (int i = 0; i < DC; i++) begin
      step(); id_pc = 32'h44 + 32'(i); settle();
      chk("drain_pc_en", 32'(pc_en), 32'd0);
    end
    step(); int_pending = 0; settle();
    chk("vec_pc_sel", 32'(pc_sel), 32'd2);
    chk("vec_inting", 32'(inting), 32'd1);
    chk("vec_pc_en", 32'(pc_en), 32'd1);
    chk("vec_epc", epc, 32'h40);
    chk("vec_stall_cnt", 32'(stall_cnt), 32'd4);
    step(); idle(); settle();
    chk("post_vec_pc_sel", 32'(pc_sel), 32'd0);

    step(); id_valid = 1; id_pc = 32'h100; int_pending = 1; settle();
    step(); wb_halt = 1; settle();
    step(); wb_halt = 0; settle();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_pc_en", 32'(pc_en), 32'd0);
    chk("halt_if_id_en", 32'(if_id_en), 32'd0);
    chk("halt_dm_wb_en", 32'(dm_wb_en), 32'd0);
    repeat (3) step();
    settle();
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_no_vector", 32'(pc_sel), 32'd0);
    do_reset();
    settle();
    chk("post_halt_pc_en", 32'(pc_en), 32'd1);

    step(); idle(); id_valid = 1; id_pc = 32'h80; int_pending = 1; settle();
    step(); int_pending = 0; settle();
    chk("mid_drain_epc", epc, 32'h80);
    step(); rst_n = 0; settle();
    chk("mid_drain_rst_epc", epc, 32'd0);
    step(); rst_n = 1; idle(); settle();
    chk("mid_drain_rst_pc_en", 32'(pc_en), 32'd1);

    step(); load_use(5'd3);
    repeat (1000) @(posedge clk);
    #1; settle();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'(SAT));
    step(); idle();

    for (int n = 0; n < 3000; n++) begin
      step();
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 199) == 0) rst_n = 0;
      id_valid        = ($urandom_range(0, 3) != 0);
      id_pc           = $urandom;
      id_rs_used      = $urandom_range(0, 1) == 1;
      id_rt_used      = $urandom_range(0, 1) == 1;
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_load         = $urandom_range(0, 2) == 0;
      ex_req_w        = 5'($urandom_range(0, 3));
      ex_branch_taken = $urandom_range(0, 5) == 0;
      int_pending     = $urandom_range(0, 7) == 0;
      wb_halt         = $urandom_range(0, 59) == 0;
    end

    step(); idle(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
